edge_counter: RTL and testbench
===============================

Name: edge_counter

Overview:
- Parametrised synchronous event counter for the LedSnake control path.
- Counts edges on an asynchronous input (button or slow strobe) modulo MODULUS, with selectable edge type, up/down direction, wrap or saturate, and parallel load.
- Emits one-cycle overflow/underflow pulses for chaining into position or speed logic.
- Single clock domain; the input is synchronised internally.

Parameters:
- CNT_W, 5, counter width in bits.
- MODULUS, 8, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**CNT_W.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..4.
- EDGE_MODE, 0, event edge: 0 = rising, 1 = falling, 2 = both.
- SAT_MODE, 0, end-of-range behaviour: 0 = wrap, 1 = saturate.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- in  in  1  asynchronous event input.
- en  in  1  count enable; events arriving while en=0 are discarded, not queued.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled in the event cycle.
- load  in  1  synchronous parallel load.
- load_val  in  CNT_W  load value.
- cnt  out  CNT_W  current count (registered).
- ovf  out  1  one-cycle pulse on an up-event at MODULUS-1.
- unf  out  1  one-cycle pulse on a down-event at 0.
- at_max  out  1  combinational: cnt == MODULUS-1.
- at_zero  out  1  combinational: cnt == 0.

Behaviour:
- Reset (rst=1 at a clk edge): cnt=0, ovf=0, unf=0, synchroniser flops=0, edge-history flop=0, arm counter=0. Reset has highest priority and aborts any pending event.
- Synchroniser: `in` passes through SYNC_STAGES flops; sync_out is the last stage.
- Edge detection compares sync_out with a one-cycle-delayed copy, prev:
  - rise = sync_out & ~prev
  - fall = ~sync_out & prev
  - event is selected by EDGE_MODE.
- Arming: after reset release, event is masked for SYNC_STAGES+1 cycles (small arm counter). An input held high through reset therefore produces no spurious event.
- Latency: with SYNC_STAGES=2, a transition on `in` settling before clk edge k updates cnt at edge k+3. In general the latency is SYNC_STAGES+1 cycles.
- Priority per cycle: rst > load > (en & event) > hold.
- Load: cnt <= min(load_val, MODULUS-1). ovf and unf stay 0. A coincident event is dropped.
- Up-event, cnt < MODULUS-1: cnt+1.
- Up-event, cnt == MODULUS-1:
  - SAT_MODE=0: cnt <= 0, ovf=1.
  - SAT_MODE=1: cnt holds, ovf=1 (pulses on every blocked event).
- Down-event, cnt > 0: cnt-1.
- Down-event, cnt == 0:
  - SAT_MODE=0: cnt <= MODULUS-1, unf=1.
  - SAT_MODE=1: cnt holds, unf=1.
- ovf and unf are registered, high for exactly one cycle per qualifying event, and never both high together.
- en=0 blocks counting only. The synchroniser and prev keep running, so raising en mid-pulse does not create an event.
- EDGE_MODE=2: each transition is a separate event. A pulse of at least 1 clk width after synchronisation counts twice.
- Arithmetic is done in CNT_W+1 bits before comparison, so MODULUS = 2**CNT_W has no width overflow.
- Elaboration-time check: an illegal MODULUS or SYNC_STAGES value halts elaboration.

Decomposition:
- Package led_snake_pkg holds:
  - EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2
  - MODE_WRAP=0, MODE_SAT=1
- One sub-module: edge_sync (synchroniser, prev flop, arm mask, EDGE_MODE select). Parameters SYNC_STAGES and EDGE_MODE. Ports clk, rst, in; output event, a one-cycle pulse.
- edge_counter instantiates edge_sync and holds the count/flag logic.

Test Plan:
1. Defaults, en=1, up=1: eight rising pulses on `in`, each 4 clk wide → cnt steps 1..7 then 0; ovf high exactly one cycle on the 8th; each update lands 3 cycles after the input edge.
2. SAT_MODE=1, up=0, cnt=0: two pulses → cnt stays 0; unf pulses twice. Then load=1, load_val=20 → cnt=7, at_max=1.
3. SAT_MODE=0, up=0, cnt=0: one pulse → cnt=7, unf=1 for one cycle, ovf=0.
4. EDGE_MODE=2, en=1, up=1, cnt=0: one 5-cycle pulse → cnt=2; with en=0, the same pulse → cnt unchanged.
5. load=1 in the same cycle an event arrives, load_val=3 → cnt=3 and no increment. rst asserted while an event is in the synchroniser → cnt=0 and no later count.
6. `in` held high through reset and released: no event for 3 cycles, and cnt stays 0 until a real falling-then-rising edge, which gives cnt=1.

Source files
------------

// File: rtl/led_snake_pkg.sv
// Shared constants for the LedSnake control path.
package led_snake_pkg;

    // Event edge selection
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    // End-of-range behaviour
    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

endpackage : led_snake_pkg

// File: rtl/edge_sync.sv
// Input synchroniser, edge detector and post-reset arm mask.
// The event output is a registered one-cycle pulse. It is named evt because
// "event" is a reserved word.
module edge_sync
    import led_snake_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = EDGE_RISE
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic evt
);

    localparam int unsigned ARM_W    = 3;
    localparam int unsigned ARM_DONE = SYNC_STAGES + 1;

    // Catch illegal configurations at elaboration.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $fatal(1, "edge_sync: SYNC_STAGES must be in 2..4");
    end
    if (EDGE_MODE > EDGE_BOTH) begin : g_bad_edge
        $fatal(1, "edge_sync: EDGE_MODE must be 0, 1 or 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [ARM_W-1:0]       arm_q;
    logic                   sync_out;
    logic                   rise;
    logic                   fall;
    logic                   edge_sel;
    logic                   armed;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign armed    = (arm_q == ARM_W'(ARM_DONE));

    // Synchroniser chain, edge history, arm counter and registered event.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            arm_q  <= '0;
            evt    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
            prev_q <= sync_out;
            arm_q  <= armed ? arm_q : arm_q + ARM_W'(1);
            evt    <= armed & edge_sel;
        end
    end

    // Edge detect and edge-type selection; masked until the chain has flushed.
    always_comb begin
        rise     = sync_out & ~prev_q;
        fall     = ~sync_out & prev_q;
        edge_sel = 1'b0;
        case (EDGE_MODE)
            EDGE_RISE: edge_sel = rise;
            EDGE_FALL: edge_sel = fall;
            EDGE_BOTH: edge_sel = rise | fall;
            default:   edge_sel = 1'b0;
        endcase
    end

endmodule : edge_sync

// File: rtl/edge_counter.sv
// Modulo event counter with direction, wrap/saturate, parallel load and
// one-cycle overflow/underflow pulses.
module edge_counter
    import led_snake_pkg::*;
#(
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned MODULUS     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = EDGE_RISE,
    parameter int unsigned SAT_MODE    = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_zero
);

    // Extended width keeps MODULUS == 2**CNT_W free of overflow.
    localparam int unsigned     EXT_W   = CNT_W + 1;
    localparam logic [CNT_W:0]  MAX_EXT = EXT_W'(MODULUS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MODULUS - 1);

    // Catch illegal configurations at elaboration.
    if (MODULUS < 2 || MODULUS > (2 ** CNT_W)) begin : g_bad_modulus
        $fatal(1, "edge_counter: MODULUS must be in 2..2**CNT_W");
    end
    if (SAT_MODE > MODE_SAT) begin : g_bad_sat
        $fatal(1, "edge_counter: SAT_MODE must be 0 or 1");
    end

    logic             evt;
    logic [CNT_W:0]   cnt_ext;
    logic [CNT_W:0]   load_ext;
    logic [CNT_W-1:0] cnt_n;
    logic             ovf_n;
    logic             unf_n;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_edge_sync (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .evt (evt)
    );

    assign cnt_ext  = {1'b0, cnt};
    assign load_ext = {1'b0, load_val};
    assign at_max   = (cnt_ext == MAX_EXT);
    assign at_zero  = (cnt == '0);

    // Count and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            cnt <= cnt_n;
            ovf <= ovf_n;
            unf <= unf_n;
        end
    end

    // Next count: load beats a coincident event; flags only on events.
    always_comb begin
        cnt_n = cnt;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        if (load) begin
            cnt_n = (load_ext > MAX_EXT) ? MAX_CNT : load_val;
        end else if (en && evt) begin
            if (up) begin
                if (cnt_ext == MAX_EXT) begin
                    ovf_n = 1'b1;
                    cnt_n = (SAT_MODE == MODE_WRAP) ? '0 : cnt;
                end else begin
                    cnt_n = CNT_W'(cnt_ext + EXT_W'(1));
                end
            end else begin
                if (cnt == '0) begin
                    unf_n = 1'b1;
                    cnt_n = (SAT_MODE == MODE_WRAP) ? MAX_CNT : cnt;
                end else begin
                    cnt_n = CNT_W'(cnt_ext - EXT_W'(1));
                end
            end
        end
    end

endmodule : edge_counter

// File: tb/tb_edge_counter.sv
// Directed bench for edge_counter: three instances (default, saturating,
// both-edge) share stimulus; each phase resets and checks one instance.
module tb_edge_counter;
    import led_snake_pkg::*;

    logic       clk;
    logic       rst;
    logic       in;
    logic       en;
    logic       up;
    logic       load;
    logic [4:0] load_val;

    logic [4:0] cnt_a, cnt_s, cnt_b;
    logic       ovf_a, ovf_s, ovf_b;
    logic       unf_a, unf_s, unf_b;
    logic       max_a, max_s, max_b;
    logic       zero_a, zero_s, zero_b;

    int n_checks = 0;
    int n_pass   = 0;

    edge_counter dut_a (
        .clk(clk), .rst(rst), .in(in), .en(en), .up(up), .load(load),
        .load_val(load_val), .cnt(cnt_a), .ovf(ovf_a), .unf(unf_a),
        .at_max(max_a), .at_zero(zero_a)
    );

    edge_counter #(.SAT_MODE(MODE_SAT)) dut_s (
        .clk(clk), .rst(rst), .in(in), .en(en), .up(up), .load(load),
        .load_val(load_val), .cnt(cnt_s), .ovf(ovf_s), .unf(unf_s),
        .at_max(max_s), .at_zero(zero_s)
    );

    edge_counter #(.EDGE_MODE(EDGE_BOTH)) dut_b (
        .clk(clk), .rst(rst), .in(in), .en(en), .up(up), .load(load),
        .load_val(load_val), .cnt(cnt_b), .ovf(ovf_b), .unf(unf_b),
        .at_max(max_b), .at_zero(zero_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] cnt_of(input int d);
        case (d)
            0:       return cnt_a;
            1:       return cnt_s;
            default: return cnt_b;
        endcase
    endfunction

    function automatic logic ovf_of(input int d);
        case (d)
            0:       return ovf_a;
            1:       return ovf_s;
            default: return ovf_b;
        endcase
    endfunction

    function automatic logic unf_of(input int d);
        case (d)
            0:       return unf_a;
            1:       return unf_s;
            default: return unf_b;
        endcase
    endfunction

    function automatic logic max_of(input int d);
        case (d)
            0:       return max_a;
            1:       return max_s;
            default: return max_b;
        endcase
    endfunction

    function automatic logic zero_of(input int d);
        case (d)
            0:       return zero_a;
            1:       return zero_s;
            default: return zero_b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset with in low, then wait out the arm window.
    task automatic do_reset();
        in  = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(5);
    endtask

    // 4-cycle-wide pulse; count must change exactly 3 cycles after the rise.
    task automatic pulse(input int d, input string tag, input logic [4:0] exp_pre,
                         input logic [4:0] exp_post, input logic exp_ovf, input logic exp_unf);
        in = 1'b1;
        cyc(3);
        check({tag, "_pre"}, 32'(cnt_of(d)), 32'(exp_pre));
        cyc(1);
        check({tag, "_cnt"}, 32'(cnt_of(d)), 32'(exp_post));
        check({tag, "_ovf"}, 32'(ovf_of(d)), 32'(exp_ovf));
        check({tag, "_unf"}, 32'(unf_of(d)), 32'(exp_unf));
        in = 1'b0;
        cyc(1);
        check({tag, "_flags_clr"}, {30'd0, ovf_of(d), unf_of(d)}, 32'd0);
        cyc(3);
    endtask

    initial begin
        rst = 1'b1; in = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;

        // Reset state and 8 up-events with wrap on the 8th
        do_reset();
        check("reset_cnt", 32'(cnt_a), 32'd0);
        check("reset_zero", 32'(zero_of(0)), 32'd1);
        check("reset_flags", {30'd0, ovf_a, unf_a}, 32'd0);
        for (int i = 0; i < 8; i++)
            pulse(0, $sformatf("up%0d", i), 5'(i), 5'((i + 1) % 8), (i == 7), 1'b0);

        // Saturating down at zero, then load clamped to MODULUS-1
        up = 1'b0;
        do_reset();
        pulse(1, "sat_dn0", 5'd0, 5'd0, 1'b0, 1'b1);
        pulse(1, "sat_dn1", 5'd0, 5'd0, 1'b0, 1'b1);
        load = 1'b1; load_val = 5'd20;
        cyc(1);
        load = 1'b0;
        check("sat_load_cnt", 32'(cnt_s), 32'd7);
        check("sat_load_max", 32'(max_of(1)), 32'd1);
        check("sat_load_flags", {30'd0, ovf_s, unf_s}, 32'd0);

        // Wrap down from zero
        do_reset();
        pulse(0, "wrap_dn", 5'd0, 5'd7, 1'b0, 1'b1);
        check("wrap_dn_max", 32'(max_a), 32'd1);

        // Both edges: one pulse counts twice; en=0 discards both
        up = 1'b1;
        do_reset();
        in = 1'b1;
        cyc(4);
        check("both_rise", 32'(cnt_b), 32'd1);
        cyc(1);
        in = 1'b0;
        cyc(6);
        check("both_fall", 32'(cnt_b), 32'd2);
        en = 1'b0;
        in = 1'b1;
        cyc(5);
        in = 1'b0;
        cyc(6);
        check("both_en0", 32'(cnt_b), 32'd2);
        en = 1'b1;

        // Load wins over a coincident event
        do_reset();
        in = 1'b1;
        cyc(3);
        load = 1'b1; load_val = 5'd3;
        cyc(1);
        load = 1'b0;
        check("load_evt_cnt", 32'(cnt_a), 32'd3);
        cyc(3);
        check("load_evt_hold", 32'(cnt_a), 32'd3);
        in = 1'b0;
        cyc(5);
        check("load_evt_fall", 32'(cnt_a), 32'd3);

        // Reset aborts an event still in the synchroniser
        in = 1'b1;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(8);
        check("rst_abort", 32'(cnt_a), 32'd0);

        // Input held high through reset: no spurious event
        in = 1'b1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check($sformatf("held_hi%0d", i), 32'(cnt_a), 32'd0);
        end
        in = 1'b0;
        cyc(5);
        check("held_fall", 32'(cnt_a), 32'd0);
        in = 1'b1;
        cyc(3);
        check("held_rise_pre", 32'(cnt_a), 32'd0);
        cyc(1);
        check("held_rise", 32'(cnt_a), 32'd1);
        in = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_edge_counter
